// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory-wait timeout, a sticky illegal-instruction trap and a retire counter.
module mips_multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int ALUCTL_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [1:0]          pc_source,
    output logic                illegal,
    output logic                timeout,
    output logic [CNT_W-1:0]    instr_retired,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WB = 4'd6,
        S_MEM_WR = 4'd7,
        S_ALU_WB = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JR     = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SLTI = 6'd2;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_SW   = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd6;
    localparam logic [5:0] OP_JR   = 6'd7;
    localparam logic [5:0] OP_JAL  = 6'd8;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(4);

    // Wait counter only needs to reach MEM_TIMEOUT-1; the limit cycle itself triggers the trap.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic                r_illegal;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_retired;

    logic [5:0]          w_opcode;
    logic [5:0]          w_funct;
    logic                w_functOk;
    logic                w_illegalOp;
    logic [ALUCTL_W-1:0] w_functAlu;
    logic                w_waitState;
    logic                w_expire;
    logic                w_retire;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];

    always_comb begin
        w_functOk  = 1'b1;
        w_functAlu = ALU_ADD;
        case (w_funct)
            6'b000001: w_functAlu = ALU_ADD;
            6'b000010: w_functAlu = ALU_SUB;
            6'b000100: w_functAlu = ALU_AND;
            6'b001000: w_functAlu = ALU_OR;
            6'b010000: w_functAlu = ALU_SLT;
            default:   w_functOk  = 1'b0;
        endcase
    end

    assign w_illegalOp = (w_opcode > OP_JAL) || ((w_opcode == OP_R) && !w_functOk);
    assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_expire    = TIMEOUT_EN && w_waitState && !mem_ready && (r_waitCnt == WAIT_LIMIT);
    // Every arc into FETCH from another state is an instruction's final cycle.
    assign w_retire    = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_waitCnt <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_waitCnt <= (w_waitState && !mem_ready && !w_expire) ? r_waitCnt + 1'b1 : '0;
            if ((r_state == S_DECODE) && w_illegalOp) r_illegal <= 1'b1;
            if (w_expire) r_timeout <= 1'b1;
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_source   = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)     w_next = S_DECODE;
                else if (w_expire) w_next = S_TRAP;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (w_illegalOp) w_next = S_TRAP;
                else begin
                    case (w_opcode)
                        OP_R:             w_next = S_EXEC_R;
                        OP_ADDI, OP_SLTI: w_next = S_EXEC_I;
                        OP_LW, OP_SW:     w_next = S_ADDR;
                        OP_BEQ:           w_next = S_BRANCH;
                        OP_J:             w_next = S_JUMP;
                        OP_JR:            w_next = S_JR;
                        OP_JAL:           w_next = S_JAL;
                        default:          w_next = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = w_functAlu;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = (w_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (w_opcode == OP_R) ? 2'b01 : 2'b00;
                w_next    = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (w_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)     w_next = S_MEM_WB;
                else if (w_expire) w_next = S_TRAP;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)     w_next = S_FETCH;
                else if (w_expire) w_next = S_TRAP;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = zero;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                w_next    = S_FETCH;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                w_next     = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        // Reset must never let a partial write escape, whatever state we are in.
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign illegal       = r_illegal;
    assign timeout       = r_timeout;
    assign instr_retired = r_retired;
    assign state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: directed test-plan steps followed by random
// instruction streams, checked against an instruction-level reference model.
module tb_mips_multicycle_controller;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic        alu_src_a, illegal, timeout;
    logic [2:0]  alu_control;
    logic [31:0] instr_retired;
    logic [3:0]  state;

    mips_multicycle_controller #(.MEM_TIMEOUT(T), .CNT_W(32), .ALUCTL_W(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_source(pc_source), .illegal(illegal),
        .timeout(timeout), .instr_retired(instr_retired), .state(state)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   mRetired = 0;
    logic mIllegal = 1'b0;
    logic mTimeout = 1'b0;

    logic [17:0] obsCtl;
    assign obsCtl = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source};

    // Control word each state should present, straight from the state descriptions.
    function automatic logic [17:0] expCtl(input int s, input logic [5:0] op, input logic [5:0] fn,
                                           input logic rdy, input logic z);
        logic pcw = 0, irw = 0, iord = 0, mr = 0, mw = 0, rw = 0, a = 0;
        logic [1:0] rd = 0, mtr = 0, b = 0, pcs = 0;
        logic [2:0] alu = 0;
        case (s)
            0:  begin mr = 1; b = 2'b01; pcw = rdy; irw = rdy; end
            1:  b = 2'b11;
            2:  begin
                    a = 1;
                    alu = (fn == 6'd2) ? 3'd1 : (fn == 6'd4) ? 3'd2 : (fn == 6'd8) ? 3'd3 :
                          (fn == 6'd16) ? 3'd4 : 3'd0;
                end
            3:  begin a = 1; b = 2'b10; alu = (op == 6'd2) ? 3'd4 : 3'd0; end
            4:  begin a = 1; b = 2'b10; end
            5:  begin mr = 1; iord = 1; end
            6:  begin rw = 1; mtr = 2'b01; end
            7:  begin mw = 1; iord = 1; end
            8:  begin rw = 1; rd = (op == 6'd0) ? 2'b01 : 2'b00; end
            9:  begin a = 1; alu = 3'd1; pcs = 2'b01; pcw = z; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin pcw = 1; pcs = 2'b11; end
            12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; end
            default: ;
        endcase
        return {pcw, irw, iord, mr, mw, rw, rd, mtr, a, b, alu, pcs};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCheck(input int s, input logic [31:0] iw, input logic rdy, input logic z);
        @(negedge clk);
        instr = iw; mem_ready = rdy; zero = z;
        #1;
        checkOutput($sformatf("state op%0d", iw[31:26]), 32'(state), 32'(s));
        checkOutput($sformatf("ctl s%0d op%0d", s, iw[31:26]), 32'(obsCtl),
                    32'(expCtl(s, iw[31:26], iw[5:0], rdy, z)));
    endtask

    // A memory wait phase: w not-ready cycles, trapping once T of them accumulate.
    task automatic runWait(input int s, input int w, input logic [31:0] iw, input logic z,
                           output bit trapped);
        trapped = 0;
        for (int i = 0; i < w && i < T; i++) stepCheck(s, iw, 1'b0, z);
        if (w >= T) begin
            trapped  = 1;
            mTimeout = 1'b1;
        end else begin
            stepCheck(s, iw, 1'b1, z);
        end
    endtask

    task automatic checkStatus(input string tag, input int s);
        @(posedge clk);
        #1;
        checkOutput({tag, " state"}, 32'(state), 32'(s));
        checkOutput({tag, " retired"}, instr_retired, 32'(mRetired));
        checkOutput({tag, " illegal"}, 32'(illegal), 32'(mIllegal));
        checkOutput({tag, " timeout"}, 32'(timeout), 32'(mTimeout));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b1;
        #1;
        checkOutput("enables in reset", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'(0));
        mRetired = 0; mIllegal = 1'b0; mTimeout = 1'b0;
        checkStatus("after reset", 0);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input int fw, input int mw);
        logic [31:0] iw = {op, 20'($urandom), fn};
        bit trapped;
        bit ill = (op > 6'd8) || (op == 6'd0 && !(fn inside {6'd1, 6'd2, 6'd4, 6'd8, 6'd16}));
        logic rnd = 1'($urandom);
        runWait(0, fw, iw, z, trapped);
        if (!trapped) begin
            stepCheck(1, iw, rnd, z);
            if (ill) begin
                trapped  = 1;
                mIllegal = 1'b1;
            end else begin
                case (op)
                    6'd0:       begin stepCheck(2, iw, rnd, z); stepCheck(8, iw, rnd, z); end
                    6'd1, 6'd2: begin stepCheck(3, iw, rnd, z); stepCheck(8, iw, rnd, z); end
                    6'd3: begin
                        stepCheck(4, iw, rnd, z);
                        runWait(5, mw, iw, z, trapped);
                        if (!trapped) stepCheck(6, iw, rnd, z);
                    end
                    6'd4: begin stepCheck(4, iw, rnd, z); runWait(7, mw, iw, z, trapped); end
                    6'd5: stepCheck(9, iw, rnd, z);
                    6'd6: stepCheck(10, iw, rnd, z);
                    6'd7: stepCheck(11, iw, rnd, z);
                    default: stepCheck(12, iw, rnd, z);
                endcase
            end
        end
        if (!trapped) mRetired++;
        checkStatus($sformatf("end op%0d", op), trapped ? 15 : 0);
        if (trapped) begin
            stepCheck(15, iw, 1'b1, 1'b1);
            doReset();
        end
    endtask

    initial begin
        logic [31:0] lwWord;
        logic [5:0]  fns [5] = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16};
        $display("[TB] start");
        doReset();
        applyStimulus(6'd0, 6'b000001, 1'b0, 0, 0);
        applyStimulus(6'd3, 6'd0, 1'b0, 0, 3);
        applyStimulus(6'd5, 6'd0, 1'b1, 0, 0);
        applyStimulus(6'd5, 6'd0, 1'b0, 0, 0);
        applyStimulus(6'd8, 6'd0, 1'b0, 0, 0);
        applyStimulus(6'd1, 6'd0, 1'b0, 1, 0);
        applyStimulus(6'd2, 6'd0, 1'b0, 0, 0);
        applyStimulus(6'd0, 6'b010000, 1'b0, 0, 0);
        applyStimulus(6'd9, 6'd0, 1'b0, 0, 0);
        applyStimulus(6'd0, 6'b000011, 1'b0, 0, 0);
        applyStimulus(6'd4, 6'd0, 1'b0, 0, T);
        applyStimulus(6'd4, 6'd0, 1'b0, 0, T - 1);
        applyStimulus(6'd6, 6'd0, 1'b0, T, 0);
        // Reset arriving mid-wait in MEM_RD must drop the read and retire nothing.
        lwWord = {6'd3, 26'h0};
        stepCheck(0, lwWord, 1'b1, 1'b0);
        stepCheck(1, lwWord, 1'b0, 1'b0);
        stepCheck(4, lwWord, 1'b0, 1'b0);
        stepCheck(5, lwWord, 1'b0, 1'b0);
        doReset();
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op = 6'($urandom_range(0, 10));
            logic [5:0] fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            int fw = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 2);
            int mw = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 2);
            applyStimulus(op, fn, 1'($urandom), fw, mw);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
